seri_add_lanes: RTL and testbench

//  Multi-lane, word-framed bit-serial adder/subtractor for the DA-FIR datapath.

---
 rtl/seri_add_lanes.sv | 144 ++++++++++++++
 tb/tb_seri_add_lanes.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seri_add_lanes.sv
// seri_add_lanes: multi-lane, word-framed bit-serial adder/subtractor.
// Each lane adds (or subtracts) two LSB-first serial operands. It produces a
// registered serial sum bit on every consumed bit. At the end of each word it
// also produces a parallel WIDTH-bit result and the final carry.
// Optional feature macro: SERI_ADD_OVF_EN adds a per-lane signed overflow output (Ovf).
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no word in progress; En without Start is ignored
// RUN   | consuming bits 1..WIDTH-1 of a word; En=0 stalls everything
module seri_add_lanes #(
    parameter int WIDTH = 16,
    parameter int LANES = 4
) (
    input  logic                    clk,
    input  logic                    Rst,
    input  logic                    En,
    input  logic                    Start,
    input  logic [LANES-1:0]        Sub,
    input  logic [LANES-1:0]        A,
    input  logic [LANES-1:0]        B,
    output logic [LANES-1:0]        S,
    output logic [LANES*WIDTH-1:0]  SumP,
    output logic [LANES-1:0]        Co,
`ifdef SERI_ADD_OVF_EN
    output logic [LANES-1:0]        Ovf,
`endif
    output logic                    Valid,
    output logic                    Busy
);

    localparam int CW = $clog2(WIDTH);
    // Counter holds the number of bits still to consume, counting down.
    // The word ends when the bit consumed with the count at 1 is taken.
    localparam logic [CW-1:0] REM_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] REM_LAST = CW'(1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t                        state;
    logic [CW-1:0]                 rem;
    logic [LANES-1:0]              carry;
    logic [LANES-1:0]              sub_l;
    logic [LANES-1:0][WIDTH-1:0]   shreg;

    logic                          consume;
    logic                          last_bit;
    logic [LANES-1:0]              sub_eff;
    logic [LANES-1:0]              c_in;
    logic [LANES-1:0]              b_eff;
    logic [LANES-1:0]              s_bit;
    logic [LANES-1:0]              c_nxt;
    logic [LANES-1:0][WIDTH-1:0]   sh_nxt;

    // Per-lane full-adder slice and next shift-register contents for the current bit.
    // On the Start bit, the fresh Sub value is both the mode and the carry-in. This gives
    // two's-complement subtraction without waiting for the latched copy.
    always_comb begin
        consume  = En & (Start | (state == ST_RUN));
        last_bit = En & ~Start & (state == ST_RUN) & (rem == REM_LAST);
        sub_eff  = '0;
        c_in     = '0;
        b_eff    = '0;
        s_bit    = '0;
        c_nxt    = '0;
        sh_nxt   = '0;
        for (int i = 0; i < LANES; i++) begin
            sub_eff[i] = Start ? Sub[i] : sub_l[i];
            c_in[i]    = Start ? Sub[i] : carry[i];
            b_eff[i]   = B[i] ^ sub_eff[i];
            s_bit[i]   = A[i] ^ b_eff[i] ^ c_in[i];
            c_nxt[i]   = (A[i] & b_eff[i]) | (A[i] & c_in[i]) | (b_eff[i] & c_in[i]);
            sh_nxt[i]  = {s_bit[i], shreg[i][WIDTH-1:1]};
        end
    end

    // Word-framing FSM, serial datapath state and all registered outputs.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state <= ST_IDLE;
            rem   <= '0;
            carry <= '0;
            sub_l <= '0;
            shreg <= '0;
            S     <= '0;
            SumP  <= '0;
            Co    <= '0;
`ifdef SERI_ADD_OVF_EN
            Ovf   <= '0;
`endif
            Valid <= 1'b0;
            Busy  <= 1'b0;
        end else begin
            Valid <= 1'b0;

            if (consume) begin
                S     <= s_bit;
                carry <= c_nxt;
                shreg <= sh_nxt;
            end

            case (state)
                ST_IDLE: begin
                    if (En && Start) begin
                        state <= ST_RUN;
                        rem   <= REM_INIT;
                        sub_l <= Sub;
                        Busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (En && Start) begin
                        // Restart: the in-flight word is dropped without a Valid.
                        rem   <= REM_INIT;
                        sub_l <= Sub;
                    end else if (last_bit) begin
                        state <= ST_IDLE;
                        rem   <= '0;
                        Busy  <= 1'b0;
                        Valid <= 1'b1;
                        for (int i = 0; i < LANES; i++) begin
                            SumP[i*WIDTH +: WIDTH] <= sh_nxt[i];
                        end
                        Co    <= c_nxt;
`ifdef SERI_ADD_OVF_EN
                        // Carry into the MSB is the carry entering this last bit.
                        Ovf   <= c_in ^ c_nxt;
`endif
                    end else if (En) begin
                        rem <= rem - REM_LAST;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    Busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seri_add_lanes.sv
// Testbench for seri_add_lanes (WIDTH=8, LANES=2) using a word-level arithmetic reference model.
module tb_seri_add_lanes;

    logic        clk;
    logic        Rst;
    logic        En;
    logic        Start;
    logic [1:0]  Sub;
    logic [1:0]  A;
    logic [1:0]  B;
    logic [1:0]  S;
    logic [15:0] SumP;
    logic [1:0]  Co;
`ifdef SERI_ADD_OVF_EN
    logic [1:0]  Ovf;
`endif
    logic        Valid;
    logic        Busy;

    int vectors;
    int miscompares;

    seri_add_lanes #(.WIDTH(8), .LANES(2)) dut (
        .clk   (clk),
        .Rst   (Rst),
        .En    (En),
        .Start (Start),
        .Sub   (Sub),
        .A     (A),
        .B     (B),
        .S     (S),
        .SumP  (SumP),
        .Co    (Co),
`ifdef SERI_ADD_OVF_EN
        .Ovf   (Ovf),
`endif
        .Valid (Valid),
        .Busy  (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs (caller sits at a falling edge), let one rising edge pass,
    // return at the next falling edge with outputs settled.
    task automatic step(input logic en, input logic st, input logic [1:0] a,
                        input logic [1:0] b, input logic [1:0] sub);
        En = en; Start = st; A = a; B = b; Sub = sub;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Stream one word per lane and check S, Valid, Busy per bit and SumP/Co/Ovf at the end.
    // gap_after >= 0 inserts a 3-cycle En=0 stall after that bit; rnd_stalls adds random stalls.
    task automatic run_word(input logic [1:0][7:0] a, input logic [1:0][7:0] b,
                            input logic [1:0] sub, input int gap_after, input bit rnd_stalls);
        logic [1:0][7:0] er;
        logic [1:0]      ec;
        logic [8:0]      t9;
        logic [7:0]      bb;
        logic [1:0]      s_prev;
        logic [15:0]     sump_prev;
        int              n;
`ifdef SERI_ADD_OVF_EN
        logic [1:0]      eo;
`endif
        for (int l = 0; l < 2; l++) begin
            bb    = sub[l] ? ~b[l] : b[l];
            t9    = {1'b0, a[l]} + {1'b0, bb} + {8'b0, sub[l]};
            er[l] = t9[7:0];
            ec[l] = t9[8];
`ifdef SERI_ADD_OVF_EN
            if (sub[l])
                eo[l] = (a[l][7] != b[l][7]) && (er[l][7] != a[l][7]);
            else
                eo[l] = (a[l][7] == b[l][7]) && (er[l][7] != a[l][7]);
`endif
        end
        for (int k = 0; k < 8; k++) begin
            n = 0;
            if (k > 0 && k == gap_after + 1) n = 3;
            else if (k > 0 && rnd_stalls) n = $urandom_range(0, 2);
            for (int j = 0; j < n; j++) begin
                s_prev    = S;
                sump_prev = SumP;
                step(1'b0, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom));
                vectors++;
                if (S !== s_prev || SumP !== sump_prev) begin
                    miscompares++;
                    $display("FAIL stall_hold: S=%b SumP=%h, expected S=%b SumP=%h", S, SumP, s_prev, sump_prev);
                end
                vectors++;
                if (Valid !== 1'b0 || Busy !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_flags: Valid=%b Busy=%b, expected Valid=0 Busy=1", Valid, Busy);
                end
            end
            step(1'b1, k == 0, {a[1][k], a[0][k]}, {b[1][k], b[0][k]},
                 (k == 0) ? sub : 2'($urandom));
            vectors++;
            if (S !== {er[1][k], er[0][k]}) begin
                miscompares++;
                $display("FAIL serial_bit%0d: S=%b, expected %b", k, S, {er[1][k], er[0][k]});
            end
            vectors++;
            if (Valid !== (k == 7) || Busy !== (k != 7)) begin
                miscompares++;
                $display("FAIL framing_bit%0d: Valid=%b Busy=%b, expected Valid=%b Busy=%b",
                         k, Valid, Busy, k == 7, k != 7);
            end
        end
        vectors++;
        if (SumP !== {er[1], er[0]}) begin
            miscompares++;
            $display("FAIL sump: got %h, expected %h", SumP, {er[1], er[0]});
        end
        vectors++;
        if (Co !== ec) begin
            miscompares++;
            $display("FAIL carry: got %b, expected %b", Co, ec);
        end
`ifdef SERI_ADD_OVF_EN
        vectors++;
        if (Ovf !== eo) begin
            miscompares++;
            $display("FAIL ovf: got %b, expected %b", Ovf, eo);
        end
`endif
    endtask

    task automatic check_all_zero(input string name);
        vectors++;
        if (S !== 2'b0 || SumP !== 16'h0 || Co !== 2'b0 || Valid !== 1'b0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s: S=%b SumP=%h Co=%b Valid=%b Busy=%b, expected all 0",
                     name, S, SumP, Co, Valid, Busy);
        end
`ifdef SERI_ADD_OVF_EN
        vectors++;
        if (Ovf !== 2'b0) begin
            miscompares++;
            $display("FAIL %s_ovf: got %b, expected 0", name, Ovf);
        end
`endif
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'($urandom_range(0, 1)), 2'($urandom), 2'($urandom), 2'($urandom));
        check_all_zero("reset");
        Rst = 1'b0;
        step(1'b0, 1'b0, 2'b0, 2'b0, 2'b0);
        check_all_zero("reset_release");
    endtask

    task automatic test_add();
        run_word({8'hFF, 8'h35}, {8'h01, 8'h4A}, 2'b00, -1, 1'b0);
    endtask

    task automatic test_sub();
        run_word({8'h20, 8'h10}, {8'h10, 8'h20}, 2'b11, -1, 1'b0);
    endtask

    task automatic test_stall();
        step(1'b0, 1'b0, 2'b0, 2'b0, 2'b0);
        run_word({8'hFF, 8'h35}, {8'h01, 8'h4A}, 2'b00, 3, 1'b0);
    endtask

    task automatic test_abort();
        logic [1:0][7:0] ar;
        logic [1:0][7:0] br;
        ar = {8'($urandom), 8'($urandom)};
        br = {8'($urandom), 8'($urandom)};
        for (int k = 0; k < 5; k++) begin
            step(1'b1, k == 0, {ar[1][k], ar[0][k]}, {br[1][k], br[0][k]}, 2'($urandom));
            vectors++;
            if (Valid !== 1'b0 || Busy !== 1'b1) begin
                miscompares++;
                $display("FAIL abort_pre%0d: Valid=%b Busy=%b, expected Valid=0 Busy=1", k, Valid, Busy);
            end
        end
        run_word({8'($urandom), 8'h01}, {8'($urandom), 8'h02}, 2'b00, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_word({8'h80, 8'h80}, {8'h80, 8'h80}, 2'b00, -1, 1'b0);
        run_word({8'($urandom), 8'($urandom)}, {8'($urandom), 8'($urandom)}, 2'($urandom), -1, 1'b0);
        run_word({8'($urandom), 8'($urandom)}, {8'($urandom), 8'($urandom)}, 2'($urandom), -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b0, 2'b0, 2'b0, 2'b0);
        for (int k = 0; k < 4; k++)
            step(1'b1, k == 0, 2'($urandom), 2'($urandom), 2'b00);
        Rst = 1'b1;
        step(1'b1, 1'b0, 2'($urandom), 2'($urandom), 2'b00);
        Rst = 1'b0;
        check_all_zero("reset_mid");
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom));
            vectors++;
            if (Valid !== 1'b0 || Busy !== 1'b0 || S !== 2'b0) begin
                miscompares++;
                $display("FAIL post_reset_idle: Valid=%b Busy=%b S=%b, expected 0 0 00", Valid, Busy, S);
            end
        end
        run_word({8'($urandom), 8'($urandom)}, {8'($urandom), 8'($urandom)}, 2'($urandom), -1, 1'b0);
    endtask

    task automatic test_random();
        logic [15:0] sump_prev;
        int          gap;
        for (int w = 0; w < 30; w++) begin
            run_word({8'($urandom), 8'($urandom)}, {8'($urandom), 8'($urandom)}, 2'($urandom), -1, 1'b1);
            gap = $urandom_range(0, 2);
            for (int j = 0; j < gap; j++) begin
                sump_prev = SumP;
                step(1'($urandom_range(0, 1)), 1'b0, 2'($urandom), 2'($urandom), 2'($urandom));
                vectors++;
                if (Valid !== 1'b0 || Busy !== 1'b0 || SumP !== sump_prev) begin
                    miscompares++;
                    $display("FAIL idle_gap: Valid=%b Busy=%b SumP=%h, expected 0 0 %h",
                             Valid, Busy, SumP, sump_prev);
                end
            end
        end
    endtask

`ifdef SERI_ADD_OVF_EN
    task automatic test_ovf();
        run_word({8'h05, 8'h7F}, {8'h03, 8'h01}, 2'b00, -1, 1'b0);
        run_word({8'h05, 8'h80}, {8'h03, 8'h01}, 2'b01, -1, 1'b0);
        run_word({8'h80, 8'h05}, {8'h7F, 8'h03}, 2'b10, -1, 1'b0);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        Rst = 1'b1; En = 1'b0; Start = 1'b0; Sub = '0; A = '0; B = '0;
        @(negedge clk);
        test_reset();
        test_add();
        test_sub();
        test_stall();
        test_abort();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef SERI_ADD_OVF_EN
        test_ovf();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
